// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave serving INCR/FIXED read and write bursts from an on-chip register-file memory
module axi_sram_slave #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH = 4,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic [1:0]            S_AXI_RRESP,
    input  logic                  S_AXI_RREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY
);
    localparam int SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> SHIFT;
    endfunction

    // Addresses below BASE_ADDR wrap to huge indices and so fall out of range too
    function automatic logic beat_ok(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] burst);
        return !burst[1] && (word_of(a) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                                   input logic [1:0] burst);
        return burst == 2'b01 ? a + (ADDR_WIDTH'(1) << size) : a;
    endfunction

    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_src;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst, r_resp;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  arready_q, ar_hs, r_hs, r_done, r_ok;

    assign ar_hs  = r_state == R_IDLE && arready_q && S_AXI_ARVALID;
    assign r_hs   = r_state == R_BURST && S_AXI_RREADY;
    assign r_done = r_hs && r_beat == r_len;
    assign r_src  = ar_hs ? S_AXI_ARADDR : step(r_addr, r_size, r_burst);
    assign r_ok   = beat_ok(r_src, ar_hs ? S_AXI_ARBURST : r_burst);
    assign r_idx  = IDX_W'(word_of(r_src));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_id      <= '0;
            r_data    <= '0;
            r_resp    <= '0;
        end else begin
            r_state   <= r_next;
            arready_q <= r_next == R_IDLE;
            if (ar_hs) begin
                r_len   <= S_AXI_ARLEN;
                r_id    <= S_AXI_ARID;
                r_size  <= S_AXI_ARSIZE;
                r_burst <= S_AXI_ARBURST;
                r_beat  <= '0;
            end else if (r_hs) begin
                r_beat <= r_beat + 8'd1;
            end
            // Nonblocking load ahead of the write block gives pre-write data on a same-word collision
            if (ar_hs || r_hs) begin
                r_addr <= r_src;
                r_data <= r_ok ? mem[r_idx] : '0;
                r_resp <= r_ok ? 2'b00 : 2'b10;
            end
        end
    end

    always_comb r_next = ar_hs ? R_BURST : r_done ? R_IDLE : r_state;

    always_comb begin
        S_AXI_ARREADY = arready_q;
        S_AXI_RVALID  = r_state == R_BURST;
        S_AXI_RLAST   = r_state == R_BURST && r_beat == r_len;
        S_AXI_RDATA   = r_data;
        S_AXI_RID     = r_id;
        S_AXI_RRESP   = r_resp;
    end

    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [ID_WIDTH-1:0]   w_id;
    logic [IDX_W-1:0]      w_idx;
    logic                  awready_q, aw_hs, w_hs, b_hs, w_last_beat, w_ok, w_err;

    assign aw_hs       = w_state == W_IDLE && awready_q && S_AXI_AWVALID;
    assign w_hs        = w_state == W_DATA && S_AXI_WVALID;
    assign b_hs        = w_state == W_RESP && S_AXI_BREADY;
    assign w_last_beat = w_beat == w_len;
    assign w_ok        = beat_ok(w_addr, w_burst);
    assign w_idx       = IDX_W'(word_of(w_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            w_addr    <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_id      <= '0;
            w_err     <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= w_next == W_IDLE;
            if (aw_hs) begin
                w_addr  <= S_AXI_AWADDR;
                w_len   <= S_AXI_AWLEN;
                w_id    <= S_AXI_AWID;
                w_size  <= S_AXI_AWSIZE;
                w_burst <= S_AXI_AWBURST;
                w_beat  <= '0;
            end else if (w_hs) begin
                w_addr <= step(w_addr, w_size, w_burst);
                w_beat <= w_beat + 8'd1;
            end
            if (w_hs)
                w_err <= w_err | !w_ok | (S_AXI_WLAST != w_last_beat);
            else if (b_hs)
                w_err <= 1'b0;
        end
    end

    always_ff @(posedge i_clk)
        if (w_hs && w_ok)
            for (int b = 0; b < STRB_WIDTH; b++)
                if (S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];

    always_comb w_next = aw_hs ? W_DATA : (w_hs && w_last_beat) ? W_RESP : b_hs ? W_IDLE : w_state;

    always_comb begin
        S_AXI_AWREADY = awready_q;
        S_AXI_WREADY  = w_state == W_DATA;
        S_AXI_BVALID  = w_state == W_RESP;
        S_AXI_BID     = w_id;
        S_AXI_BRESP   = {w_err, 1'b0};
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_axi_sram_slave;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] araddr = '0, awaddr = '0, rdata, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0, wstrb = '0;
    logic [3:0]  arid = '0, awid = '0, rid, bid;
    logic [2:0]  arsize = '0, awsize = '0;
    logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
    logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b1;

    axi_sram_slave dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARLEN(arlen),
        .S_AXI_ARID(arid), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_RDATA(rdata), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RID(rid),
        .S_AXI_RRESP(rresp), .S_AXI_RREADY(rready),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWLEN(awlen),
        .S_AXI_AWID(awid), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready)
    );

    typedef struct packed {logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id;} r_exp_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];
    logic [63:0] wd [8];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_r(input logic [63:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
        r_q.push_back('{data: d, resp: resp, last: last, id: id});
    endtask

    task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
        b_q.push_back('{id: id, resp: resp});
    endtask

    initial begin
        logic        hold_v;
        logic [71:0] hold;
        r_exp_t      e;
        b_exp_t      be;
        hold_v = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) chk("r_hold", {rvalid, rdata, rlast, rresp, rid}, hold);
                if (rvalid) chk("arready_busy", arready, 0);
                if (rvalid && rready) begin
                    if (r_q.size() == 0) bad("r_unexpected");
                    else begin
                        e = r_q.pop_front();
                        chk("rdata", rdata, e.data);
                        chk("rresp", rresp, e.resp);
                        chk("rlast", rlast, e.last);
                        chk("rid", rid, e.id);
                    end
                end
                if (bvalid && bready) begin
                    if (b_q.size() == 0) bad("b_unexpected");
                    else begin
                        be = b_q.pop_front();
                        chk("bresp", bresp, be.resp);
                        chk("bid", bid, be.id);
                    end
                end
                hold_v = rvalid && !rready;
                hold = {rvalid, rdata, rlast, rresp, rid};
            end
        end
    end

    task automatic ar_send(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] id);
        int t;
        t = 0;
        araddr = a; arlen = l; arsize = 3'd3; arburst = b; arid = id; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 50) begin t++; @(negedge clk); end
        if (!arready) bad("ar_timeout");
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] id);
        int t;
        t = 0;
        awaddr = a; awlen = l; awsize = 3'd3; awburst = b; awid = id; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 50) begin t++; @(negedge clk); end
        if (!awready) bad("aw_timeout");
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic last);
        int t;
        t = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && t < 50) begin t++; @(negedge clk); end
        if (!wready) bad("w_timeout");
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic b_wait();
        int t;
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 50) begin t++; @(negedge clk); end
        if (!bvalid) bad("b_timeout");
        @(posedge clk); #1;
    endtask

    task automatic r_drain(input int n, input bit stall);
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            rready = stall ? (cyc % 3 == 0) : 1'b1;
            @(negedge clk);
            if (rvalid && rready) got++;
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        if (got < n) bad("r_timeout");
    endtask

    task automatic wr(input logic [63:0] a, input logic [1:0] burst, input logic [3:0] id, input int n,
                      input logic [7:0] strb, input logic [1:0] resp);
        exp_b(id, resp);
        aw_send(a, 8'(n - 1), burst, id);
        for (int i = 0; i < n; i++) w_send(wd[i], strb, i == n - 1);
        b_wait();
    endtask

    task automatic rd(input logic [63:0] a, input logic [1:0] burst, input logic [3:0] id, input int n, input bit stall);
        ar_send(a, 8'(n - 1), burst, id);
        r_drain(n, stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_ctrl", {arready, awready, wready, rvalid, rlast, bvalid}, 0);
        chk("reset_data", {rdata, rid, rresp, bid, bresp}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("ready_before_edge", {arready, awready}, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", {arready, awready}, 2'b11);

        // basic INCR write then read back
        wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
        wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
        wr(BASE, INCR, 4'h2, 4, 8'hFF, 2'b00);
        for (int i = 0; i < 4; i++) exp_r(wd[i], 2'b00, i == 3, 4'h1);
        rd(BASE, INCR, 4'h1, 4, 1'b0);

        // partial strobe on word 5
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(BASE + 64'h28, INCR, 4'h3, 1, 8'hFF, 2'b00);
        wd[0] = 64'h0;
        wr(BASE + 64'h28, INCR, 4'h3, 1, 8'h0F, 2'b00);
        exp_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'h4);
        rd(BASE + 64'h28, INCR, 4'h4, 1, 1'b0);

        // 8-beat read under RREADY backpressure
        for (int i = 0; i < 8; i++) wd[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        wr(BASE + 64'h40, INCR, 4'h5, 8, 8'hFF, 2'b00);
        for (int i = 0; i < 8; i++) exp_r(wd[i], 2'b00, i == 7, 4'h6);
        rd(BASE + 64'h40, INCR, 4'h6, 8, 1'b1);

        // burst running off the top of memory
        wd[0] = 64'hDEAD_BEEF_0123_4567; wd[1] = 64'h5555_5555_5555_5555;
        wr(BASE + 64'h1FF8, INCR, 4'h7, 2, 8'hFF, 2'b10);
        exp_r(64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 4'h8);
        exp_r(64'h0, 2'b10, 1'b1, 4'h8);
        rd(BASE + 64'h1FF8, INCR, 4'h8, 2, 1'b0);

        // WRAP read is an error burst of full length
        for (int i = 0; i < 4; i++) exp_r(64'h0, 2'b10, i == 3, 4'h9);
        rd(BASE, WRAP, 4'h9, 4, 1'b0);

        // early WLAST
        exp_b(4'hA, 2'b10);
        aw_send(BASE + 64'hA0, 8'd2, INCR, 4'hA);
        w_send(64'h1, 8'hFF, 1'b1);
        w_send(64'h2, 8'hFF, 1'b0);
        w_send(64'h3, 8'hFF, 1'b1);
        b_wait();

        // FIXED write and read stay on one word
        wd[0] = 64'hAAAA_0000_0000_000A; wd[1] = 64'hBBBB_0000_0000_000B;
        wr(BASE + 64'hF0, FIXED, 4'hB, 2, 8'hFF, 2'b00);
        exp_r(64'hBBBB_0000_0000_000B, 2'b00, 1'b1, 4'hC);
        rd(BASE + 64'hF0, INCR, 4'hC, 1, 1'b0);
        exp_r(64'hBBBB_0000_0000_000B, 2'b00, 1'b0, 4'hC);
        exp_r(64'hBBBB_0000_0000_000B, 2'b00, 1'b1, 4'hC);
        rd(BASE + 64'hF0, FIXED, 4'hC, 2, 1'b0);

        // WRAP write leaves memory untouched
        wd[0] = 64'h0101_0101_0101_0101;
        wr(BASE + 64'hF8, INCR, 4'h1, 1, 8'hFF, 2'b00);
        wd[0] = 64'h0202_0202_0202_0202;
        wr(BASE + 64'hF8, WRAP, 4'h1, 1, 8'hFF, 2'b10);
        exp_r(64'h0101_0101_0101_0101, 2'b00, 1'b1, 4'h1);
        rd(BASE + 64'hF8, INCR, 4'h1, 1, 1'b0);

        // overlapped read of words 40..43 and write of words 41..44, colliding each cycle
        for (int i = 0; i < 5; i++) wd[i] = 64'h0000_0000_0000_0A00 + 64'(i);
        wr(BASE + 64'h140, INCR, 4'h2, 5, 8'hFF, 2'b00);
        for (int i = 0; i < 4; i++) exp_r(64'h0000_0000_0000_0A00 + 64'(i), 2'b00, i == 3, 4'h4);
        for (int i = 0; i < 4; i++) wd[i] = 64'hBEEF_0000_0000_0000 + 64'(i);
        fork
            wr(BASE + 64'h148, INCR, 4'h3, 4, 8'hFF, 2'b00);
            rd(BASE + 64'h140, INCR, 4'h4, 4, 1'b0);
        join
        for (int i = 0; i < 4; i++) exp_r(64'hBEEF_0000_0000_0000 + 64'(i), 2'b00, i == 3, 4'h5);
        rd(BASE + 64'h148, INCR, 4'h5, 4, 1'b0);

        // reset in the middle of a stalled read and an unacknowledged write response
        ar_send(BASE + 64'h40, 8'd7, INCR, 4'h0);
        bready = 1'b0;
        aw_send(BASE + 64'h1E0, 8'd0, INCR, 4'h5);
        w_send(64'h6060_6060_6060_6060, 8'hFF, 1'b1);
        @(negedge clk);
        chk("pre_reset_valid", {rvalid, bvalid}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("reset_abort", {rvalid, bvalid, arready, awready, wready}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        bready = 1'b1;
        @(posedge clk); #1;
        exp_r(64'h6060_6060_6060_6060, 2'b00, 1'b1, 4'h7);
        rd(BASE + 64'h1E0, INCR, 4'h7, 1, 1'b0);
        wd[0] = 64'h5050_5050_5050_5050;
        wr(BASE + 64'h190, INCR, 4'h3, 1, 8'hFF, 2'b00);
        exp_r(64'h5050_5050_5050_5050, 2'b00, 1'b1, 4'h3);
        rd(BASE + 64'h190, INCR, 4'h3, 1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("r_q_empty", r_q.size(), 0);
        chk("b_q_empty", b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
